text_display_buffer: RTL and testbench

Parametrised memory-mapped character buffer for text displays: a ROWS×COLS array of ASCII cells is read and written by the CPU at byte granularity. Each store marks its cell dirty, and a round-robin scanner streams dirty cells to a downstream display controller over a valid/ready port, so only changed characters are re-sent. It replaces the fixed 4×16 display memory and sits on the data-memory bus beside data RAM. Hardware clear and full-refresh commands are included.

---
 rtl/text_display_buffer.sv | 99 +++++++++
 tb/tb_text_display_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_display_buffer.sv
// text_display_buffer: CPU-mapped ROWS x COLS character store with dirty tracking,
// streaming changed cells to a display controller over valid/ready.
module text_display_buffer #(
    parameter int ROWS = 4,
    parameter int COLS = 16,
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    localparam int N = ROWS * COLS,
    localparam int AW = $clog2(N)
) (
    input  logic          clock_mem,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    store_data,
    input  logic          store_we,
    output logic [7:0]    load_data,
    input  logic          clear,
    input  logic          refresh,
    output logic          busy,
    output logic          pending,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [7:0]    out_data
);
    typedef enum logic {RUN, SWEEP} state_t;
    state_t        r_state, w_state_nxt;
    logic [7:0]    r_cell [N];
    logic [N-1:0]  r_dirty, w_dirty_nxt;
    logic [AW-1:0] r_scan, r_sweep, r_oaddr;
    logic [7:0]    r_odata, r_load;
    logic          r_valid;
    logic          w_run, w_free, w_cap, w_we;

    assign w_run  = r_state == RUN;
    assign w_free = !r_valid || out_ready;
    assign w_cap  = w_run && w_free && r_dirty[r_scan];
    assign w_we   = w_run && store_we;

    always_comb begin
        w_state_nxt = w_run ? (clear ? SWEEP : RUN) : (r_sweep == AW'(N - 1) ? RUN : SWEEP);
    end

    // later assignments win: refresh > store/sweep set > capture clear
    always_comb begin
        w_dirty_nxt = r_dirty;
        if (w_cap) w_dirty_nxt[r_scan] = 1'b0;
        if (w_we) w_dirty_nxt[addr] = 1'b1;
        if (!w_run) w_dirty_nxt[r_sweep] = 1'b1;
        if (refresh) w_dirty_nxt = '1;
    end

    always_ff @(posedge clock_mem) begin
        if (rst) begin
            r_state <= SWEEP;
            r_sweep <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dirty <= w_dirty_nxt;
            r_sweep <= w_run ? '0 : r_sweep + 1'b1;
        end
    end

    always_ff @(posedge clock_mem) begin
        if (!rst) begin
            if (!w_run) r_cell[r_sweep] <= CLEAR_CHAR;
            else if (store_we) r_cell[addr] <= store_data;
        end
    end

    always_ff @(posedge clock_mem) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_oaddr <= '0;
            r_odata <= '0;
            r_scan  <= '0;
            r_load  <= '0;
        end else begin
            r_load <= r_cell[addr];
            if (w_run && w_free) begin
                r_valid <= r_dirty[r_scan];
                if (r_dirty[r_scan]) begin
                    r_oaddr <= r_scan;
                    r_odata <= r_cell[r_scan];
                end
                r_scan <= r_scan + 1'b1;
            end else if (!w_run && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign load_data = r_load;
    assign busy      = !w_run;
    assign pending   = !rst && |r_dirty;
    assign out_valid = r_valid;
    assign out_addr  = r_oaddr;
    assign out_data  = r_odata;
endmodule

// File: tb/tb_text_display_buffer.sv
// tb_text_display_buffer: scoreboard bench for the 4x16 text buffer; expected
// transfers are queued as stimulus is driven and checked on each handshake.
module tb_text_display_buffer;
    localparam int N = 64;
    localparam int AW = 6;

    logic          clock_mem = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [7:0]    store_data = '0;
    logic          store_we = 1'b0;
    logic          clear = 1'b0;
    logic          refresh = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    load_data, out_data;
    logic          busy, pending, out_valid;
    logic [AW-1:0] out_addr;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] q[$];
    logic [13:0] exp_x;
    logic [7:0]  model [N];

    text_display_buffer dut (
        .clock_mem(clock_mem), .rst(rst), .addr(addr), .store_data(store_data),
        .store_we(store_we), .load_data(load_data), .clear(clear), .refresh(refresh),
        .busy(busy), .pending(pending), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clock_mem = ~clock_mem;

    always @(negedge clock_mem) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected got %0d/%h", out_addr, out_data);
            end else begin
                exp_x = q.pop_front();
                if ({out_addr, out_data} !== exp_x) begin
                    errors++;
                    $display("FAIL xfer got %0d/%h want %0d/%h", out_addr, out_data, exp_x[13:8], exp_x[7:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock_mem);
        #1;
    endtask

    task automatic push(input int a);
        q.push_back({AW'(a), model[a]});
    endtask

    task automatic store(input int a, input logic [7:0] d);
        addr = AW'(a);
        store_data = d;
        store_we = 1'b1;
        step();
        store_we = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain left %0d want 0 queued", nm, q.size());
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL %s_pending got %b want 0", nm, pending);
        end
    endtask

    task automatic pin(input int k);
        int n = 0;
        out_ready = 1'b0;
        push(k);
        store(k, model[k]);
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_addr !== AW'(k)) begin
            errors++;
            $display("FAIL pin_%0d got v=%b a=%0d want v=1 a=%0d", k, out_valid, out_addr, k);
        end
    endtask

    task automatic test_reset();
        int cnt = 0;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++;
        if ({out_valid, out_addr, out_data} !== 15'd0) begin
            errors++;
            $display("FAIL rst_out got %b/%0d/%h want 0/0/00", out_valid, out_addr, out_data);
        end
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", pending); end
        checks++;
        if (load_data !== 8'h00) begin errors++; $display("FAIL rst_load got %h want 00", load_data); end
        for (int i = 0; i < N; i++) begin
            model[i] = 8'h20;
            push(i);
        end
        out_ready = 1'b1;
        rst = 1'b0;
        while (busy && cnt < 200) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt !== 64) begin errors++; $display("FAIL rst_busy_len got %0d want 64", cnt); end
        wait_drain("reset");
    endtask

    task automatic test_store();
        out_ready = 1'b1;
        model[5] = 8'h41;
        push(5);
        store(5, 8'h41);
        checks++;
        if (load_data !== 8'h20) begin errors++; $display("FAIL store_rbw got %h want 20", load_data); end
        step();
        checks++;
        if (load_data !== 8'h41) begin errors++; $display("FAIL store_load got %h want 41", load_data); end
        wait_drain("store");
    endtask

    task automatic test_stall();
        pin(5);
        model[5] = 8'h42;
        push(5);
        store(5, 8'h42);
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 6'd5 || out_data !== 8'h41) begin
            errors++;
            $display("FAIL stall_hold got %b/%0d/%h want 1/5/41", out_valid, out_addr, out_data);
        end
        out_ready = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_collide();
        pin(9);
        store(10, model[10]);
        push(10);
        model[10] = 8'h58;
        push(10);
        out_ready = 1'b1;
        store(10, 8'h58);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 6'd10 || out_data !== 8'h20) begin
            errors++;
            $display("FAIL collide_cap got %b/%0d/%h want 1/10/20", out_valid, out_addr, out_data);
        end
        wait_drain("collide");
    endtask

    task automatic test_refresh();
        pin(0);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        for (int i = 1; i <= N; i++) push(i % N);
        out_ready = 1'b1;
        wait_drain("refresh_clean");
        pin(0);
        store(1, model[1]);
        push(1);
        for (int i = 2; i <= N + 1; i++) push(i % N);
        out_ready = 1'b1;
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        wait_drain("refresh_cap");
    endtask

    task automatic test_clear();
        int cnt = 0;
        pin(3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < N; i++) model[i] = 8'h20;
        for (int i = 4; i < N + 4; i++) push(i % N);
        while (busy && cnt < 200) begin
            if (cnt == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_addr !== 6'd3) begin
                    errors++;
                    $display("FAIL clear_hold got %b/%0d want 1/3", out_valid, out_addr);
                end
                out_ready = 1'b1;
            end
            if (cnt == 6) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_drop got %b want 0", out_valid); end
            end
            if (cnt == 40) begin
                addr = 6'd7;
                store_data = 8'h77;
                store_we = 1'b1;
            end
            if (cnt == 41) store_we = 1'b0;
            cnt++;
            step();
        end
        checks++;
        if (cnt !== 64) begin errors++; $display("FAIL clear_busy_len got %0d want 64", cnt); end
        wait_drain("clear");
        for (int i = 0; i < N; i++) begin
            addr = AW'(i);
            step();
            checks++;
            if (load_data !== model[i]) begin
                errors++;
                $display("FAIL clear_cell_%0d got %h want %h", i, load_data, model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_stall();
        test_collide();
        test_refresh();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
